// File: rtl/single_argmax_if.sv
// Valid/ready bundle between the element stream, single_argmax and the result consumer.
// The out_nan wire exists only when SINGLE_ARGMAX_NAN_EN is defined.
interface single_argmax_if #(parameter int IDX_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_max;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W-1:0] out_count;
  logic             out_ovf;
`ifdef SINGLE_ARGMAX_NAN_EN
  logic             out_nan;
`endif

  modport master (
    output in_valid, in_data, in_last, out_ready,
`ifdef SINGLE_ARGMAX_NAN_EN
    input  out_nan,
`endif
    input  in_ready, out_valid, out_max, out_idx, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
`ifdef SINGLE_ARGMAX_NAN_EN
    output out_nan,
`endif
    output in_ready, out_valid, out_max, out_idx, out_count, out_ovf
  );
endinterface

// File: rtl/single_argmax.sv
// Streaming arg-max over single-precision vectors: one element per cycle, result held until taken.
// Optional feature macro SINGLE_ARGMAX_NAN_EN: NaNs never win and out_nan flags their presence.
module single_argmax #(
  parameter int IDX_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  single_argmax_if.slave bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      max_q, max_d;
  logic [31:0]      out_max_q, out_max_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [IDX_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             xfer, first, take;
  logic [31:0]      new_max;
  logic [IDX_W-1:0] new_idx;
`ifdef SINGLE_ARGMAX_NAN_EN
  logic             nan_q, nan_d;
  logic             max_nan_q, max_nan_d;
  logic             out_nan_q, out_nan_d;
  logic             in_nan;
`endif

  // Comparator ordering: sign first, then magnitude (inverted for negatives); equal bits never win.
  function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
    if (a == b)              return 1'b0;
    else if (a[31] != b[31]) return !a[31];
    else if (!a[31])         return a[30:0] > b[30:0];
    else                     return a[30:0] < b[30:0];
  endfunction

  assign bus.in_ready  = (state_q == ACCUM) && !rst;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_max   = out_max_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;
`ifdef SINGLE_ARGMAX_NAN_EN
  assign bus.out_nan   = out_nan_q;
`endif

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    max_d       = max_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    xfer  = bus.in_valid && bus.in_ready;
    // After a wrap the counter is 0 again, so the sticky bit separates "first" from "wrapped".
    first = (cnt_q == '0) && !ovf_q;
`ifdef SINGLE_ARGMAX_NAN_EN
    nan_d     = nan_q;
    max_nan_d = max_nan_q;
    out_nan_d = out_nan_q;
    in_nan    = (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] != 23'd0);
    take      = first || (!in_nan && (max_nan_q || gt(bus.in_data, max_q)));
`else
    take      = first || gt(bus.in_data, max_q);
`endif
    new_max = take ? bus.in_data : max_q;
    new_idx = take ? cnt_q : idx_q;

    unique case (state_q)
      ACCUM: begin
        if (xfer) begin
          max_d = new_max;
          idx_d = new_idx;
          cnt_d = cnt_q + IDX_W'(1);
          ovf_d = ovf_q | (&cnt_q);
`ifdef SINGLE_ARGMAX_NAN_EN
          max_nan_d = take ? in_nan : max_nan_q;
          nan_d     = nan_q | in_nan;
`endif
          if (bus.in_last) begin
            out_max_d   = new_max;
            out_idx_d   = new_idx;
            out_count_d = cnt_q;
            out_ovf_d   = ovf_q;
            cnt_d       = '0;
            ovf_d       = 1'b0;
`ifdef SINGLE_ARGMAX_NAN_EN
            out_nan_d   = nan_q | in_nan;
            nan_d       = 1'b0;
`endif
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
      state_q     <= ACCUM;
      cnt_q       <= '0;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      max_q       <= '0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
`ifdef SINGLE_ARGMAX_NAN_EN
      nan_q       <= 1'b0;
      max_nan_q   <= 1'b0;
      out_nan_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      max_q       <= max_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
`ifdef SINGLE_ARGMAX_NAN_EN
      nan_q       <= nan_d;
      max_nan_q   <= max_nan_d;
      out_nan_q   <= out_nan_d;
`endif
    end
  end

endmodule
